// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter, MSB first, valid/ready load, optional even parity (PISO_PARITY_EN).
// Ports: CLK clock; N_RESET async active-high reset; LOAD_DATA/LOAD_VALID/LOAD_READY word handshake;
// DATA_OUT serial bit; OUT_VALID frame-bit qualifier; DONE pulse on the final bit of each frame.
module piso_shift_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             N_RESET,
  input  logic [WIDTH-1:0] LOAD_DATA,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             DATA_OUT,
  output logic             OUT_VALID,
  output logic             DONE
);
  localparam int CW = $clog2(WIDTH);
`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic accept, last;
`ifdef PISO_PARITY_EN
  logic par, par_n;
  assign last = state == PARITY;
  assign DATA_OUT = state == SHIFT ? sreg[WIDTH-1] : (state == PARITY && par);
`else
  assign last = state == SHIFT && cnt == '0;
  assign DATA_OUT = state == SHIFT && sreg[WIDTH-1];
`endif
  assign OUT_VALID = state != IDLE;
  assign DONE = last;
  // the final-bit cycle also accepts so frames can run back to back
  assign LOAD_READY = state == IDLE || last;
  assign accept = LOAD_VALID && LOAD_READY;
  always_comb begin
    state_n = state;
    sreg_n = sreg;
    cnt_n = cnt;
`ifdef PISO_PARITY_EN
    par_n = par;
`endif
    if (accept) begin
      state_n = SHIFT;
      sreg_n = LOAD_DATA;
      cnt_n = CW'(WIDTH - 1);
`ifdef PISO_PARITY_EN
      par_n = ^LOAD_DATA;
`endif
    end else if (state == SHIFT) begin
      sreg_n = sreg << 1;
      cnt_n = cnt == '0 ? '0 : cnt - 1'b1;
`ifdef PISO_PARITY_EN
      state_n = cnt == '0 ? PARITY : SHIFT;
`else
      state_n = cnt == '0 ? IDLE : SHIFT;
`endif
    end
`ifdef PISO_PARITY_EN
    else if (state == PARITY) state_n = IDLE;
`endif
  end
  always_ff @(posedge CLK or posedge N_RESET) begin
    if (N_RESET) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      cnt <= cnt_n;
    end
  end
`ifdef PISO_PARITY_EN
  always_ff @(posedge CLK or posedge N_RESET) begin
    if (N_RESET) par <= 1'b0;
    else par <= par_n;
  end
`endif
endmodule

// File: doc/piso_shift_tx.md
# piso_shift_tx

Parallel-in, serial-out shift transmitter. It accepts a WIDTH-bit word over a valid/ready load handshake and shifts it out one bit per CLK cycle, MSB first, with a frame-valid qualifier. It is the transmit end paired with the cascaded-DFF serial-in shift register: looping DATA_OUT into that receiver's DATA_IN reproduces the word on its parallel Q after WIDTH clocks.

## Interface
- WIDTH, default 8: word width in bits; legal range ≥ 2.
- CLK  input  1  clock; all state updates on the rising edge.
- N_RESET  input  1  reset, asynchronous, active-high.
- LOAD_DATA  input  WIDTH  parallel word to transmit.
- LOAD_VALID  input  1  LOAD_DATA is valid.
- LOAD_READY  output  1  block can accept a word this cycle.
- DATA_OUT  output  1  serial bit stream, MSB first.
- OUT_VALID  output  1  DATA_OUT carries a frame bit this cycle.
- DONE  output  1  one-cycle pulse coincident with the final bit of a frame.

## Operation
- State machine states:
  - IDLE: no frame in progress.
  - SHIFT: data bits being sent.
  - PARITY: parity bit being sent; this state exists only with PISO_PARITY_EN.
- Transfer: a word is accepted on a rising edge where LOAD_VALID && LOAD_READY.
- On acceptance:
  - LOAD_DATA is captured into the shift register.
  - The bit counter is set to WIDTH-1.
  - The FSM goes to SHIFT.
- SHIFT:
  - DATA_OUT = shift_reg[WIDTH-1] and OUT_VALID = 1.
  - Each edge shifts left by one (LSB filled with 0) and decrements the counter.
  - When the counter reaches 0 the final bit is on DATA_OUT: the FSM goes to PARITY if that feature is enabled, otherwise to IDLE (or reloads, see below).
- LOAD_READY = 1 in IDLE, and also during the final bit cycle of a frame (the last data bit, or the parity bit if enabled). This permits back-to-back frames with no idle gap.
- Acceptance on the final-bit edge: the new word loads directly and the FSM stays in or returns to SHIFT.
- LOAD_VALID while LOAD_READY = 0 is ignored. The upstream holds LOAD_VALID and LOAD_DATA until accepted; no data is lost or corrupted.
- DONE = 1 exactly during the final bit cycle of each frame.
- IDLE outputs: DATA_OUT = 0, OUT_VALID = 0.
- Reset (N_RESET = 1, at any time, including mid-frame):
  - The frame is aborted immediately and the FSM goes to IDLE.
  - The shift register and counter clear to 0.
  - Output values: DATA_OUT = 0, OUT_VALID = 0, DONE = 0, LOAD_READY = 1.
  - No partial frame resumes after reset is released.

## Timing
- Load-to-first-bit latency: 1 cycle. The word accepted at edge k has its MSB on DATA_OUT after edge k.
- Frame length: WIDTH cycles of OUT_VALID, or WIDTH+1 with PISO_PARITY_EN.
- Throughput: one frame per WIDTH (or WIDTH+1) cycles when LOAD_VALID is held high.
- All outputs are registered or decoded from registered state only. There is no combinational path from LOAD_VALID or LOAD_DATA to any output.
- Sampling: DATA_OUT is stable for the full cycle. The receiver samples it on the next rising edge; the same edge timing as the receiver's negedge-driven, posedge-sampled stimulus is met.

## Configuration
- PISO_PARITY_EN defined:
  - After the last data bit, one extra bit is sent: the even-parity bit (XOR of all WIDTH data bits), with OUT_VALID = 1.
  - DONE and the back-to-back LOAD_READY window move to that parity cycle.
  - Parity is computed from LOAD_DATA at acceptance and held in a register.
- PISO_PARITY_EN undefined:
  - The PARITY state and parity register are not compiled.
  - The frame is exactly WIDTH bits.

## Test plan
- Basic frame:
  - Stimulus: reset, then WIDTH=8, load 8'hAD.
  - Response: DATA_OUT = 1,0,1,0,1,1,0,1 on the 8 cycles after acceptance; OUT_VALID high for exactly 8 cycles; DONE on the 8th; loopback SIPO Q = 8'b10101101.
- Back-to-back:
  - Stimulus: load 8'hAD, with LOAD_VALID held to present 8'h3C at the final-bit edge.
  - Response: 16 consecutive OUT_VALID cycles; stream 10101101 00111100; no gap; 2 DONE pulses.
- Busy hold:
  - Stimulus: assert LOAD_VALID with 8'hFF in the 3rd bit cycle of an 8'hAD frame.
  - Response: 8'hAD completes unaltered; 8'hFF is accepted only at the final-bit edge and then sent as eight 1s.
- Reset mid-frame:
  - Stimulus: assert N_RESET during the 4th bit of 8'hAD.
  - Response: DATA_OUT, OUT_VALID and DONE all 0 asynchronously and LOAD_READY = 1; after release, the line stays idle until a new load.
- Parity (PISO_PARITY_EN):
  - Stimulus: load 8'hAD.
  - Response: 9 valid bits 10101101 then 1; DONE on the 9th. A load of 8'h3C sends parity 0.
- Width parameter:
  - Stimulus: WIDTH=4, load 4'b1001.
  - Response: DATA_OUT = 1,0,0,1; OUT_VALID for 4 cycles; LOAD_READY high again in the 4th cycle.
